stack_test_sched: RTL and testbench

Bottom-layer scheduler that sequences per-chip self-test across a 3D stack once chip-ID sorting has completed. It addresses each sorted chip ID in turn with a test-command frame on the shared 32-bit inter-layer bus and waits for a matching response, with timeout and bounded retry. It accumulates pass/fail bitmaps for the host. It sits on the first layer, beside the ID-sort/self-test block, and consumes that block's sort_finish and chip count.

---
 rtl/stack_test_sched.sv | 153 +++++++++++++++
 tb/tb_stack_test_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_test_sched.sv
// stack_test_sched: after chip-ID sort, addresses each sorted chip with a self-test frame and
// collects pass/fail bitmaps. Define STACK_TEST_SCHED_RETRY_EN to enable retries on timeout.
module stack_test_sched #(
    parameter int MAX_CHIPS = 8,
    parameter int TIMEOUT   = 36,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sort_finish,
    input  logic [4:0]           chip_count,
    input  logic [31:0]          rx_data,
    input  logic                 rx_valid,
    output logic [31:0]          tx_data,
    output logic                 tx_valid,
    output logic                 busy,
    output logic                 done,
    output logic [MAX_CHIPS-1:0] pass_map,
    output logic [MAX_CHIPS-1:0] fail_map
);

`ifdef STACK_TEST_SCHED_RETRY_EN
    localparam int RETRY_LIM = MAX_RETRY;
`else
    localparam int RETRY_LIM = 0;
`endif

    localparam int               TMR_W     = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(RETRY_LIM);
    localparam logic [4:0]       CHIP_MAX  = 5'(MAX_CHIPS);
    localparam logic [15:0]      SYNC      = 16'hBEAF;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_SORT = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_RSP  = 3'd3;
    localparam logic [2:0] S_NEXT      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [4:0]           count;
    logic [4:0]           target;
    logic [3:0]           attempt;
    logic [TMR_W-1:0]     timer;
    logic [MAX_CHIPS-1:0] tgt_mask;
    logic                 rsp_hit;
    logic                 rsp_pass;
    logic                 timer_exp;
    logic                 unused_rx;

    function automatic logic [4:0] sat_count(input logic [4:0] raw);
        return (raw > CHIP_MAX) ? CHIP_MAX : raw;
    endfunction

    function automatic logic [31:0] make_frame(input logic [3:0] att, input logic [4:0] tgt);
        return {2'b10, att, 5'd0, tgt, SYNC};
    endfunction

    // Response must come back addressed from the current target; [20:16] carries no meaning.
    assign rsp_hit   = rx_valid && (rx_data[31:30] == 2'b01) && (rx_data[15:0] == SYNC) &&
                       (rx_data[25:21] == target);
    assign rsp_pass  = (rx_data[29:26] == 4'd0);
    assign unused_rx = ^rx_data[20:16];
    assign timer_exp = (timer == TMR_LAST);
    assign tgt_mask  = MAX_CHIPS'(1) << (target - 5'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_WAIT_SORT;
            end
            S_WAIT_SORT: begin
                if (sort_finish) state_nxt = (chip_count == 5'd0) ? S_DONE : S_SEND;
            end
            S_SEND: begin
                state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                // A response in the expiry cycle still wins over the timeout.
                if (rsp_hit) state_nxt = S_NEXT;
                else if (timer_exp) state_nxt = (attempt != RETRY_MAX) ? S_SEND : S_NEXT;
            end
            S_NEXT: begin
                state_nxt = (target == count) ? S_DONE : S_SEND;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= 5'd0;
            target   <= 5'd1;
            attempt  <= 4'd0;
            timer    <= '0;
            tx_data  <= 32'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_map <= '0;
            fail_map <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done     <= (state_nxt == S_DONE);
            tx_valid <= (state == S_SEND);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_map <= '0;
                        fail_map <= '0;
                        attempt  <= 4'd0;
                        target   <= 5'd1;
                    end
                end
                S_WAIT_SORT: begin
                    if (sort_finish) count <= sat_count(chip_count);
                end
                S_SEND: begin
                    tx_data <= make_frame(attempt, target);
                    timer   <= '0;
                end
                S_WAIT_RSP: begin
                    if (rsp_hit) begin
                        if (rsp_pass) pass_map <= pass_map | tgt_mask;
                        else          fail_map <= fail_map | tgt_mask;
                    end else if (timer_exp) begin
                        if (attempt != RETRY_MAX) attempt  <= attempt + 4'd1;
                        else                      fail_map <= fail_map | tgt_mask;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (target != count) begin
                        target  <= target + 5'd1;
                        attempt <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_test_sched.sv
// Randomized self-checking bench for stack_test_sched; predicts frames, strobe cycles and maps
// from a per-chip response plan (silent attempts, status, reply delay).
module tb_stack_test_sched;
    localparam int MAX_CHIPS = 8;
    localparam int TIMEOUT   = 36;
    localparam int MAX_RETRY = 3;
`ifdef STACK_TEST_SCHED_RETRY_EN
    localparam int EFF_RETRY = MAX_RETRY;
`else
    localparam int EFF_RETRY = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 sort_finish;
    logic [4:0]           chip_count;
    logic [31:0]          rx_data;
    logic                 rx_valid;
    logic [31:0]          tx_data;
    logic                 tx_valid;
    logic                 busy;
    logic                 done;
    logic [MAX_CHIPS-1:0] pass_map;
    logic [MAX_CHIPS-1:0] fail_map;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-chip plan: attempts ignored before replying, reply status, reply delay after tx_valid.
    int silent [32];
    int rstat  [32];
    int dly    [32];

    stack_test_sched #(.MAX_CHIPS(MAX_CHIPS), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .start(start), .sort_finish(sort_finish),
        .chip_count(chip_count), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done),
        .pass_map(pass_map), .fail_map(fail_map)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic plan_all(input int s, input int st, input int d);
        for (int i = 0; i < 32; i++) begin
            silent[i] = s;
            rstat[i]  = st;
            dly[i]    = d;
        end
    endtask

    task automatic drive_junk(input int k);
        logic [4:0] wid;
        wid = 5'((k % 31) + 1);
        rx_valid = 1'b1;
        case ($urandom_range(0, 3))
            0:       rx_data = {2'b01, 4'h0, wid, 5'd0, 16'hBEAF};
            1:       rx_data = {2'b01, 4'h0, 5'(k), 5'd0, 16'hBEEF};
            2:       rx_data = {2'b10, 4'h0, 5'(k), 5'd0, 16'hBEAF};
            default: begin
                rx_valid = 1'b0;
                rx_data  = {2'b01, 4'h0, 5'(k), 5'd0, 16'hBEAF};
            end
        endcase
    endtask

    task automatic run(input int cc, input int sort_dly, input bit chaos, input int abort_k);
        int n, t, next_t, stray, c0, junk_at, resp_at, x;
        bit respond, last, done_m1, done_m2;
        logic [MAX_CHIPS-1:0] exp_pass, exp_fail;
        logic [31:0] exp_frame;
        n = (cc > MAX_CHIPS) ? MAX_CHIPS : cc;
        exp_pass = '0;
        exp_fail = '0;
        stray = 0;
        done_m1 = 1'b0;
        done_m2 = 1'b1;
        chip_count  = 5'(cc);
        sort_finish = (sort_dly == 0);
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", {63'd0, busy}, 64'd1);
        check_eq("done_after_start", {63'd0, done}, 64'd0);
        check_eq("maps_cleared", {48'd0, pass_map, fail_map}, 64'd0);
        if (sort_dly > 0) begin
            repeat (sort_dly) begin
                if (tx_valid) stray++;
                @(negedge clk);
            end
            sort_finish = 1'b1;
        end
        if (n == 0) begin
            @(negedge clk);
            check_eq("zero_done", {63'd0, done}, 64'd1);
            check_eq("zero_busy", {63'd0, busy}, 64'd0);
            repeat (6) begin
                if (tx_valid) stray++;
                @(negedge clk);
            end
            check_eq("zero_no_tx", 64'(stray), 64'd0);
            return;
        end
        next_t = c0 + 3 + sort_dly;
        while (cyc < next_t) begin
            if (tx_valid) stray++;
            @(negedge clk);
        end
        for (int k = 1; k <= n; k++) begin
            for (int a = 0; a <= EFF_RETRY; a++) begin
                t = cyc;
                exp_frame = {2'b10, 4'(a), 5'd0, 5'(k), 16'hBEAF};
                check_eq($sformatf("tx_valid_c%0d_a%0d", k, a), {63'd0, tx_valid}, 64'd1);
                check_eq($sformatf("tx_data_c%0d_a%0d", k, a), {32'd0, tx_data}, {32'd0, exp_frame});
                respond = (a >= silent[k]);
                last = (k == n) && (respond || a == EFF_RETRY);
                if (respond) begin
                    resp_at = t + dly[k];
                    next_t  = resp_at + 3;
                    junk_at = (dly[k] > 0) ? t + int'($urandom_range(0, dly[k] - 1)) : -1;
                end else begin
                    resp_at = -1;
                    next_t  = t + TIMEOUT + ((a == EFF_RETRY) ? 2 : 1);
                    junk_at = t + int'($urandom_range(0, TIMEOUT - 1));
                end
                while (cyc < next_t) begin
                    x = cyc;
                    if (x == resp_at) begin
                        rx_valid = 1'b1;
                        rx_data  = {2'b01, 4'(rstat[k]), 5'(k), 5'($urandom), 16'hBEAF};
                    end else if (chaos && x == junk_at) begin
                        drive_junk(k);
                    end else begin
                        rx_valid = 1'b0;
                        rx_data  = $urandom();
                    end
                    start = chaos && (x == t + 1);
                    if (chaos && x == t + 2) begin
                        sort_finish = 1'b0;
                        chip_count  = 5'($urandom);
                    end
                    if (x > t && tx_valid) stray++;
                    if (last && x == next_t - 1) done_m1 = done;
                    if (last && x == next_t - 2) done_m2 = done;
                    if (k == abort_k && a == 0 && x == t + 5) begin
                        check_eq("pre_abort_pass", {56'd0, pass_map}, {56'd0, exp_pass});
                        rst = 1'b1;
                        start = 1'b0;
                        rx_valid = 1'b0;
                        @(negedge clk);
                        rst = 1'b0;
                        check_eq("abort_busy", {63'd0, busy}, 64'd0);
                        check_eq("abort_done", {63'd0, done}, 64'd0);
                        check_eq("abort_tx_valid", {63'd0, tx_valid}, 64'd0);
                        check_eq("abort_maps", {48'd0, pass_map, fail_map}, 64'd0);
                        repeat (TIMEOUT + 4) begin
                            if (tx_valid || busy) stray++;
                            @(negedge clk);
                        end
                        check_eq("abort_stays_idle", 64'(stray), 64'd0);
                        return;
                    end
                    @(negedge clk);
                end
                rx_valid = 1'b0;
                start    = 1'b0;
                if (respond) begin
                    if (rstat[k] == 0) exp_pass[k-1] = 1'b1;
                    else               exp_fail[k-1] = 1'b1;
                    break;
                end
                if (a == EFF_RETRY) exp_fail[k-1] = 1'b1;
            end
        end
        check_eq("done_edge_before", {63'd0, done_m2}, 64'd0);
        check_eq("done_edge", {63'd0, done_m1}, 64'd1);
        check_eq("end_done", {63'd0, done}, 64'd1);
        check_eq("end_busy", {63'd0, busy}, 64'd0);
        check_eq("end_tx_valid", {63'd0, tx_valid}, 64'd0);
        check_eq("pass_map", {56'd0, pass_map}, {56'd0, exp_pass});
        check_eq("fail_map", {56'd0, fail_map}, {56'd0, exp_fail});
        check_eq("no_stray_tx", 64'(stray), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sort_finish = 1'b0;
        chip_count = 5'd0;
        rx_valid = 1'b0;
        rx_data = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check_eq("rst_tx_data", {32'd0, tx_data}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_maps", {48'd0, pass_map, fail_map}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three chips all passing after three cycles.
        plan_all(0, 0, 3);
        run(3, 0, 1'b0, 0);
        // Chip 2 never answers: full retry ladder then fail.
        plan_all(0, 0, 3);
        silent[2] = 99;
        run(2, 0, 1'b0, 0);
        // Fail status is final, no retry.
        plan_all(0, 0, 2);
        rstat[1] = 5;
        run(2, 0, 1'b0, 0);
        // Only malformed / misaddressed words for chip 1.
        plan_all(0, 0, 4);
        silent[1] = 99;
        run(1, 0, 1'b1, 0);
        // Reply in the very last cycle of the window.
        plan_all(0, 0, TIMEOUT - 1);
        run(2, 0, 1'b0, 0);
        // Reset while waiting on chip 2.
        plan_all(0, 0, 1);
        silent[2] = 99;
        run(2, 0, 1'b0, 2);
        // Empty stack, with and without sort delay.
        run(0, 0, 1'b0, 0);
        run(0, 3, 1'b0, 0);
        // chip_count above MAX_CHIPS, and a late sort_finish.
        plan_all(0, 0, 0);
        run(20, 2, 1'b0, 0);
        run(2, 5, 1'b1, 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 32; i++) begin
                silent[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, EFF_RETRY + 1)) : 0;
                rstat[i]  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
                dly[i]    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT - 1))
                                                        : int'($urandom_range(0, 5));
            end
            run(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), 1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
